// File: rtl/sysid_checker.sv
// rtl/sysid_checker.sv - Avalon-MM system ID / build timestamp checker
//
// Reads word 0 (system ID) and word 1 (build timestamp) from an Avalon-MM
// slave and compares both against the expected values. A check runs once
// after reset when AUTO_START=1, and again on every start request made while
// the checker is not busy. A per-read stall counter can abort a read that
// stays stalled for too long.
//
// Ports:
//   clock, reset_n          clock; asynchronous active-low reset
//   start                   request a new check (ignored while busy)
//   avm_address, avm_read   read master address/strobe (registered)
//   avm_waitrequest         slave stall
//   avm_readdata            slave read data, valid on the completing cycle
//   busy                    check in progress
//   done                    check finished, held until the next check starts
//   id_ok, ts_ok            captured words match the expected values
//   timeout                 check aborted by the stall counter
//   read_id, read_ts        last captured ID / timestamp words

module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd1380908974,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1278499610,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] read_id,
  output logic [31:0] read_ts
);

  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  // Count value seen on the last permitted stalled cycle of a read.
  localparam logic [15:0] TO_LAST = TO_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RD_ID = 2'd1,
    S_RD_TS = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        auto_q, auto_d;
  logic [15:0] stall_q, stall_d;
  logic        avm_read_q, avm_read_d;
  logic        avm_address_q, avm_address_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        timeout_q, timeout_d;
  logic [31:0] read_id_q, read_id_d;
  logic [31:0] read_ts_q, read_ts_d;

  logic        launch;
  logic        abort;
  logic        stalled;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      auto_q        <= AUTO_START;
      stall_q       <= 16'd0;
      avm_read_q    <= 1'b0;
      avm_address_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      id_ok_q       <= 1'b0;
      ts_ok_q       <= 1'b0;
      timeout_q     <= 1'b0;
      read_id_q     <= 32'd0;
      read_ts_q     <= 32'd0;
    end else begin
      state_q       <= state_d;
      auto_q        <= auto_d;
      stall_q       <= stall_d;
      avm_read_q    <= avm_read_d;
      avm_address_q <= avm_address_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      id_ok_q       <= id_ok_d;
      ts_ok_q       <= ts_ok_d;
      timeout_q     <= timeout_d;
      read_id_q     <= read_id_d;
      read_ts_q     <= read_ts_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    auto_d        = auto_q;
    stall_d       = stall_q;
    avm_read_d    = avm_read_q;
    avm_address_d = avm_address_q;
    busy_d        = busy_q;
    done_d        = done_q;
    id_ok_d       = id_ok_q;
    ts_ok_d       = ts_ok_q;
    timeout_d     = timeout_q;
    read_id_d     = read_id_q;
    read_ts_d     = read_ts_q;
    launch        = 1'b0;
    abort         = 1'b0;
    stalled       = avm_read_q && avm_waitrequest;

    case (state_q)
      S_IDLE: begin
        // The automatic check is only armed by reset, so it fires at most once.
        launch = start || auto_q;
      end
      S_DONE: begin
        launch = start;
      end
      S_RD_ID: begin
        if (!stalled) begin
          read_id_d     = avm_readdata;
          state_d       = S_RD_TS;
          stall_d       = 16'd0;
          avm_address_d = 1'b1;
        end else if (TO_EN && (stall_q == TO_LAST)) begin
          abort = 1'b1;
        end else begin
          stall_d = stall_q + 16'd1;
        end
      end
      S_RD_TS: begin
        // Completion is tested first so a read finishing on the threshold
        // cycle is accepted instead of timing out.
        if (!stalled) begin
          read_ts_d     = avm_readdata;
          state_d       = S_DONE;
          avm_read_d    = 1'b0;
          avm_address_d = 1'b0;
          busy_d        = 1'b0;
          done_d        = 1'b1;
          id_ok_d       = (read_id_q == EXPECTED_ID);
          ts_ok_d       = (avm_readdata == EXPECTED_TIMESTAMP);
        end else if (TO_EN && (stall_q == TO_LAST)) begin
          abort = 1'b1;
        end else begin
          stall_d = stall_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (launch) begin
      state_d       = S_RD_ID;
      auto_d        = 1'b0;
      stall_d       = 16'd0;
      avm_read_d    = 1'b1;
      avm_address_d = 1'b0;
      busy_d        = 1'b1;
      done_d        = 1'b0;
      id_ok_d       = 1'b0;
      ts_ok_d       = 1'b0;
      timeout_d     = 1'b0;
    end

    if (abort) begin
      state_d       = S_DONE;
      avm_read_d    = 1'b0;
      avm_address_d = 1'b0;
      busy_d        = 1'b0;
      done_d        = 1'b1;
      id_ok_d       = 1'b0;
      ts_ok_d       = 1'b0;
      timeout_d     = 1'b1;
    end
  end

  assign avm_address = avm_address_q;
  assign avm_read    = avm_read_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout     = timeout_q;
  assign read_id     = read_id_q;
  assign read_ts     = read_ts_q;

endmodule

// File: tb/tb_sysid_checker.sv
// tb/tb_sysid_checker.sv - self-checking bench for sysid_checker
//
// Instance 0: AUTO_START=1, TIMEOUT_CYCLES=4. Instance 1: AUTO_START=0,
// TIMEOUT_CYCLES=0. Each has a bench slave whose stall length per word is
// programmable, and a behavioural model checked against it every cycle.

module tb_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd1380908974;
  localparam logic [31:0] EXP_TS = 32'd1278499610;
  localparam int          STUCK  = 1000000;
  localparam int          TO_P   [2] = '{4, 0};
  localparam bit          AUTO_P [2] = '{1'b1, 1'b0};

  logic        clock;
  logic        reset_n        [2];
  logic        start          [2];
  logic        avm_address    [2];
  logic        avm_read       [2];
  logic        waitreq        [2];
  logic [31:0] rdata          [2];
  logic        busy           [2];
  logic        done           [2];
  logic        id_ok          [2];
  logic        ts_ok          [2];
  logic        timeout        [2];
  logic [31:0] read_id        [2];
  logic [31:0] read_ts        [2];

  int          cfg_id         [2];
  int          cfg_ts         [2];
  int          sctr           [2];
  logic [31:0] id_val         [2];
  logic [31:0] ts_val         [2];

  int          n_checks = 0;
  int          n_fail   = 0;

  sysid_checker #(.TIMEOUT_CYCLES(4), .AUTO_START(1'b1)) dut0 (
    .clock(clock), .reset_n(reset_n[0]), .start(start[0]),
    .avm_address(avm_address[0]), .avm_read(avm_read[0]),
    .avm_waitrequest(waitreq[0]), .avm_readdata(rdata[0]),
    .busy(busy[0]), .done(done[0]), .id_ok(id_ok[0]), .ts_ok(ts_ok[0]),
    .timeout(timeout[0]), .read_id(read_id[0]), .read_ts(read_ts[0])
  );

  sysid_checker #(.TIMEOUT_CYCLES(0), .AUTO_START(1'b0)) dut1 (
    .clock(clock), .reset_n(reset_n[1]), .start(start[1]),
    .avm_address(avm_address[1]), .avm_read(avm_read[1]),
    .avm_waitrequest(waitreq[1]), .avm_readdata(rdata[1]),
    .busy(busy[1]), .done(done[1]), .id_ok(id_ok[1]), .ts_ok(ts_ok[1]),
    .timeout(timeout[1]), .read_id(read_id[1]), .read_ts(read_ts[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Slave: stalls the first cfg cycles of each read of the addressed word.
  assign waitreq[0] = avm_read[0] && (sctr[0] < (avm_address[0] ? cfg_ts[0] : cfg_id[0]));
  assign waitreq[1] = avm_read[1] && (sctr[1] < (avm_address[1] ? cfg_ts[1] : cfg_id[1]));
  assign rdata[0]   = avm_address[0] ? ts_val[0] : id_val[0];
  assign rdata[1]   = avm_address[1] ? ts_val[1] : id_val[1];

  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (!avm_read[i] || !waitreq[i]) sctr[i] <= 0;
      else                             sctr[i] <= sctr[i] + 1;
    end
  end

  // Behavioural model. word: -1 = not reading, 0 = ID, 1 = timestamp.
  int          m_word   [2] = '{-1, -1};
  bit          m_done   [2] = '{1'b0, 1'b0};
  bit          m_auto   [2] = '{1'b0, 1'b0};
  int          m_wait   [2] = '{0, 0};
  bit          m_idok   [2] = '{1'b0, 1'b0};
  bit          m_tsok   [2] = '{1'b0, 1'b0};
  bit          m_to     [2] = '{1'b0, 1'b0};
  logic [31:0] m_rid    [2] = '{32'd0, 32'd0};
  logic [31:0] m_rts    [2] = '{32'd0, 32'd0};

  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset_n[i]) begin
        m_word[i] = -1; m_done[i] = 0; m_auto[i] = AUTO_P[i]; m_wait[i] = 0;
        m_idok[i] = 0;  m_tsok[i] = 0; m_to[i] = 0; m_rid[i] = 0; m_rts[i] = 0;
      end else if (m_word[i] < 0) begin
        if (start[i] || (!m_done[i] && m_auto[i])) begin
          m_word[i] = 0; m_wait[i] = 0; m_auto[i] = 0;
          m_done[i] = 0; m_idok[i] = 0; m_tsok[i] = 0; m_to[i] = 0;
        end
      end else if (!waitreq[i]) begin
        if (m_word[i] == 0) begin
          m_rid[i] = rdata[i]; m_word[i] = 1; m_wait[i] = 0;
        end else begin
          m_rts[i]  = rdata[i]; m_word[i] = -1; m_done[i] = 1;
          m_idok[i] = (m_rid[i] == EXP_ID);
          m_tsok[i] = (rdata[i] == EXP_TS);
        end
      end else if (TO_P[i] != 0 && m_wait[i] + 1 == TO_P[i]) begin
        m_word[i] = -1; m_done[i] = 1; m_to[i] = 1; m_idok[i] = 0; m_tsok[i] = 0;
      end else begin
        m_wait[i] = m_wait[i] + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset_n[i]) begin
        chk($sformatf("rst_read[%0d]", i), avm_read[i], 0);
        chk($sformatf("rst_busy[%0d]", i), busy[i], 0);
        chk($sformatf("rst_done[%0d]", i), done[i], 0);
        chk($sformatf("rst_rid[%0d]", i), read_id[i], 0);
      end else begin
        chk($sformatf("avm_read[%0d]", i), avm_read[i], m_word[i] >= 0);
        chk($sformatf("avm_address[%0d]", i), avm_address[i], m_word[i] == 1);
        chk($sformatf("busy[%0d]", i), busy[i], m_word[i] >= 0);
        chk($sformatf("done[%0d]", i), done[i], m_done[i]);
        chk($sformatf("id_ok[%0d]", i), id_ok[i], m_idok[i]);
        chk($sformatf("ts_ok[%0d]", i), ts_ok[i], m_tsok[i]);
        chk($sformatf("timeout[%0d]", i), timeout[i], m_to[i]);
        chk($sformatf("read_id[%0d]", i), read_id[i], m_rid[i]);
        chk($sformatf("read_ts[%0d]", i), read_ts[i], m_rts[i]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = '{1'b0, 1'b0};
    start   = '{1'b0, 1'b0};
    cfg_id  = '{0, 0};
    cfg_ts  = '{0, 0};
    id_val  = '{EXP_ID, EXP_ID};
    ts_val  = '{EXP_TS, EXP_TS};

    // Automatic check with a zero-wait slave: done on the third edge.
    step(3);
    reset_n[0] = 1'b1; reset_n[1] = 1'b1;
    step(2);
    chk("auto_done_e2", done[0], 0);
    step(1);
    chk("auto_done_e3", done[0], 1);
    chk("auto_id_ok", id_ok[0], 1);
    chk("auto_ts_ok", ts_ok[0], 1);
    chk("auto_timeout", timeout[0], 0);
    chk("noauto_idle_read", avm_read[1], 0);

    // Wrong ID word.
    id_val[0] = 32'd0;
    start[0] = 1'b1; step(1); start[0] = 1'b0;
    chk("bad_done_cleared", done[0], 0);
    step(2);
    chk("bad_done", done[0], 1);
    chk("bad_id_ok", id_ok[0], 0);
    chk("bad_ts_ok", ts_ok[0], 1);
    chk("bad_read_id", read_id[0], 32'd0);
    id_val[0] = EXP_ID;

    // Three stalled cycles per read; completion lands on the threshold count.
    cfg_id[0] = 3; cfg_ts[0] = 3;
    start[0] = 1'b1; step(1); start[0] = 1'b0;
    step(7);
    chk("stall_done_e8", done[0], 0);
    chk("stall_addr_e8", avm_address[0], 1);
    step(1);
    chk("stall_done_e9", done[0], 1);
    chk("stall_id_ok", id_ok[0], 1);
    chk("stall_ts_ok", ts_ok[0], 1);
    chk("stall_timeout", timeout[0], 0);

    // Stuck slave times out after four stalled cycles, then recovers.
    cfg_id[0] = STUCK; cfg_ts[0] = 0;
    start[0] = 1'b1; step(1); start[0] = 1'b0;
    step(3);
    chk("to_read_e4", avm_read[0], 1);
    step(1);
    chk("to_read_e5", avm_read[0], 0);
    chk("to_flag", timeout[0], 1);
    chk("to_done", done[0], 1);
    chk("to_id_ok", id_ok[0], 0);
    cfg_id[0] = 0;
    start[0] = 1'b1; step(1); start[0] = 1'b0;
    step(2);
    chk("rec_timeout", timeout[0], 0);
    chk("rec_id_ok", id_ok[0], 1);
    chk("rec_ts_ok", ts_ok[0], 1);

    // Reset during a stalled timestamp read.
    cfg_ts[0] = STUCK;
    start[0] = 1'b1; step(1); start[0] = 1'b0;
    step(2);
    chk("rst_pre_addr", avm_address[0], 1);
    reset_n[0] = 1'b0;
    #1;
    chk("rst_now_read", avm_read[0], 0);
    chk("rst_now_addr", avm_address[0], 0);
    chk("rst_now_busy", busy[0], 0);
    chk("rst_now_rid", read_id[0], 0);
    chk("rst_now_rts", read_ts[0], 0);
    chk("rst_now_done", done[0], 0);
    cfg_ts[0] = 0;
    step(2);
    reset_n[0] = 1'b1;
    step(1);
    chk("rst_re_read", avm_read[0], 1);
    chk("rst_re_addr", avm_address[0], 0);
    step(2);
    chk("rst_re_done", done[0], 1);
    chk("rst_re_id_ok", id_ok[0], 1);

    // No automatic start; extra start pulses while busy are dropped.
    chk("noauto_busy", busy[1], 0);
    cfg_id[1] = 2; cfg_ts[1] = 2;
    start[1] = 1'b1; step(1); start[1] = 1'b0;
    step(1);
    start[1] = 1'b1; step(2); start[1] = 1'b0;
    step(3);
    chk("one_done_e7", done[1], 1);
    step(3);
    chk("one_done_e10", done[1], 1);
    chk("one_busy_e10", busy[1], 0);
    chk("one_read_e10", avm_read[1], 0);

    // Timeout disabled: a 300-cycle stall is waited out.
    cfg_id[1] = 300; cfg_ts[1] = 0;
    start[1] = 1'b1; step(1); start[1] = 1'b0;
    step(300);
    chk("long_busy", busy[1], 1);
    chk("long_timeout", timeout[1], 0);
    step(2);
    chk("long_done", done[1], 1);
    chk("long_id_ok", id_ok[1], 1);
    chk("long_ts_ok", ts_ok[1], 1);

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sysid_checker.md
SYSID_CHECKER -- requirements
Module: sysid_checker

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- EXPECTED_ID, 1380908974, system ID value expected at slave word 0.
- EXPECTED_TIMESTAMP, 1278499610, build timestamp expected at slave word 1.
- TIMEOUT_CYCLES, 255, max stalled cycles per read; 0 disables timeout; range 0..65535.
- AUTO_START, 1, 1 = run one check automatically after reset.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clock, in, 1, single clock; all state on rising edge.
- reset_n, in, 1, reset; asynchronous, active-low.
- start, in, 1, request a new check; sampled each clock.
- avm_address, out, 1, Avalon-MM word address (0 = ID, 1 = timestamp).
- avm_read, out, 1, Avalon-MM read strobe.
- avm_waitrequest, in, 1, slave stall; a read completes on a cycle with avm_read=1 and avm_waitrequest=0.
- avm_readdata, in, 32, read data; valid on the completing cycle.
- busy, out, 1, check in progress.
- done, out, 1, check finished; level held until next check starts.
- id_ok, out, 1, captured ID equals EXPECTED_ID.
- ts_ok, out, 1, captured timestamp equals EXPECTED_TIMESTAMP.
- timeout, out, 1, check aborted by stall timeout.
- read_id, out, 32, last captured ID word.
- read_ts, out, 32, last captured timestamp word.

Function
REQ-003 The checker SHALL be an Avalon-MM read master with states IDLE, RD_ID, RD_TS, DONE.
REQ-004 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-005 IDLE -> RD_ID SHALL occur on the first edge after reset release when AUTO_START=1, else on an edge with start=1.
REQ-006 RD_ID SHALL drive avm_read=1 and avm_address=0; on the completing cycle: capture avm_readdata into read_id, go to RD_TS.
REQ-007 RD_TS SHALL drive avm_read=1 and avm_address=1; on the completing cycle: capture avm_readdata into read_ts, go to DONE.
REQ-008 Zero-wait slave latency SHALL be: RD_ID 1 cycle, RD_TS 1 cycle; done=1 on the 3rd edge after leaving IDLE.
REQ-009 avm_address and avm_read SHALL stay stable while avm_waitrequest=1; no read issued in IDLE or DONE.
REQ-010 In DONE: done=1, busy=0, id_ok=(read_id==EXPECTED_ID), ts_ok=(read_ts==EXPECTED_TIMESTAMP); full 32-bit unsigned compare.
REQ-011 busy SHALL be 1 exactly in RD_ID and RD_TS.
REQ-012 start=1 in DONE or IDLE SHALL go to RD_ID next edge and clear done, id_ok, ts_ok, timeout; read_id/read_ts keep old values until recaptured.
REQ-013 start while busy SHALL be ignored (no queued request).
REQ-014 A 16-bit stall counter SHALL clear on entry to each read state and increment each cycle with avm_read=1 and avm_waitrequest=1.
REQ-015 If TIMEOUT_CYCLES!=0 and the counter equals TIMEOUT_CYCLES-1 while avm_waitrequest=1, the next edge SHALL go to DONE with avm_read=0, timeout=1, id_ok=0, ts_ok=0.
REQ-016 A completion on the same cycle as the timeout threshold SHALL win: data captured, no timeout.
REQ-017 With TIMEOUT_CYCLES=0 the checker SHALL wait indefinitely.

Reset
REQ-018 reset_n=0 SHALL immediately force state IDLE, avm_read=0, avm_address=0, busy=0, done=0, id_ok=0, ts_ok=0, timeout=0, read_id=0, read_ts=0, stall counter=0, including mid-read.
REQ-019 After reset release the AUTO_START rule (REQ-005) SHALL apply anew.

Verification
REQ-020 Zero-wait slave returning 1380908974 / 1278499610, AUTO_START=1 -> done=1 on edge 3, id_ok=1, ts_ok=1, timeout=0.
REQ-021 Slave returns ID 0x00000000 -> done=1, id_ok=0, ts_ok=1, read_id=0.
REQ-022 waitrequest high 3 cycles on each read -> done on edge 9, addresses stable while stalled, both ok=1.
REQ-023 TIMEOUT_CYCLES=4, waitrequest stuck high -> avm_read drops and timeout=1, done=1 after 4 stalled cycles; pulse start with normal slave -> timeout=0, both ok=1.
REQ-024 reset_n asserted during RD_TS stall -> all outputs 0 immediately; on release a fresh check runs from address 0.
REQ-025 AUTO_START=0: no read until start pulse; start pulses while busy cause exactly one check.
